// File: rtl/idecode_pipe.sv
// idecode_pipe: MIPS-style instruction decode stage with a 32-entry register
// file, write-through bypass and an ID/EX pipeline register.
// Optional feature: define ID_HAZARD_DETECT_EN to enable load-use stall detection;
// without it, stall is tied low and no load-use bubbles are inserted.
module idecode_pipe #(
   parameter int DATA_W        = 32,
   parameter bit REG_INIT_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_id_instr,
   input  logic [DATA_W-1:0] if_id_npc,
   input  logic              if_id_valid,
   input  logic [4:0]        wb_rd,
   input  logic              wb_regwrite,
   input  logic [DATA_W-1:0] wb_writedata,
   input  logic              ex_flush,
   output logic              stall,
   output logic              id_ex_valid,
   output logic [1:0]        wb_ctlout,
   output logic [2:0]        m_ctlout,
   output logic              regdst,
   output logic              alusrc,
   output logic [1:0]        aluop,
   output logic [DATA_W-1:0] npcout,
   output logic [DATA_W-1:0] rdata1out,
   output logic [DATA_W-1:0] rdata2out,
   output logic [DATA_W-1:0] s_extendout,
   output logic [4:0]        instrout_2521,
   output logic [4:0]        instrout_2016,
   output logic [4:0]        instrout_1511
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   logic [DATA_W-1:0] r_regs [32];

   logic [5:0]        w_opcode;
   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [1:0]        w_wb;
   logic [2:0]        w_m;
   logic              w_regdst;
   logic              w_alusrc;
   logic [1:0]        w_aluop;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;
   logic [DATA_W-1:0] w_sext;
   logic              w_bubble;

   assign w_opcode = if_id_instr[31:26];
   assign w_rs     = if_id_instr[25:21];
   assign w_rt     = if_id_instr[20:16];
   assign w_rd     = if_id_instr[15:11];
   assign w_sext   = DATA_W'($signed(if_id_instr[15:0]));

   // Main control decode: opcode to WB/M/EX control fields, unknown opcodes give all zeros
   always_comb begin
      w_wb     = 2'b00;
      w_m      = 3'b000;
      w_regdst = 1'b0;
      w_alusrc = 1'b0;
      w_aluop  = 2'b00;
      case (w_opcode)
         OP_RTYPE: begin
            w_wb     = 2'b10;
            w_regdst = 1'b1;
            w_aluop  = 2'b10;
         end
         OP_LW: begin
            w_wb     = 2'b11;
            w_m      = 3'b010;
            w_alusrc = 1'b1;
         end
         OP_SW: begin
            w_m      = 3'b001;
            w_alusrc = 1'b1;
         end
         OP_BEQ: begin
            w_m      = 3'b100;
            w_aluop  = 2'b01;
         end
         default: begin
            w_wb     = 2'b00;
         end
      endcase
   end

   // Register file reads; r0 is hard zero and a same-cycle writeback is forwarded
   always_comb begin
      w_rdata1 = '0;
      w_rdata2 = '0;
      if (w_rs != 5'd0) begin
         if (wb_regwrite && (wb_rd == w_rs)) w_rdata1 = wb_writedata;
         else                                w_rdata1 = r_regs[w_rs];
      end
      if (w_rt != 5'd0) begin
         if (wb_regwrite && (wb_rd == w_rt)) w_rdata2 = wb_writedata;
         else                                w_rdata2 = r_regs[w_rt];
      end
   end

`ifdef ID_HAZARD_DETECT_EN
   logic w_usesRt;
   logic w_loadUse;

   assign w_usesRt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || (w_opcode == OP_BEQ);

   // Load in EX whose destination is a source of the instruction now in ID
   always_comb begin
      w_loadUse = id_ex_valid && m_ctlout[1] && (instrout_2016 != 5'd0) && if_id_valid &&
                  ((instrout_2016 == w_rs) || (w_usesRt && (instrout_2016 == w_rt)));
   end

   // A flushed instruction never needs to wait, and reset always releases the hold
   assign stall = w_loadUse && !ex_flush && !rst;
`else
   assign stall = 1'b0;
`endif

   assign w_bubble = ex_flush || stall || !if_id_valid;

   // Register file write port; reset optionally clears it and always blocks writebacks
   always_ff @(posedge clk) begin
      if (rst) begin
         if (REG_INIT_ZERO) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
         end
      end else if (wb_regwrite && (wb_rd != 5'd0)) begin
         r_regs[wb_rd] <= wb_writedata;
      end
   end

   // ID/EX pipeline register; bubbles zero the control fields but data still loads
   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_valid   <= 1'b0;
         wb_ctlout     <= 2'b00;
         m_ctlout      <= 3'b000;
         regdst        <= 1'b0;
         alusrc        <= 1'b0;
         aluop         <= 2'b00;
         npcout        <= '0;
         rdata1out     <= '0;
         rdata2out     <= '0;
         s_extendout   <= '0;
         instrout_2521 <= 5'd0;
         instrout_2016 <= 5'd0;
         instrout_1511 <= 5'd0;
      end else begin
         id_ex_valid   <= !w_bubble;
         wb_ctlout     <= w_bubble ? 2'b00 : w_wb;
         m_ctlout      <= w_bubble ? 3'b000 : w_m;
         regdst        <= w_bubble ? 1'b0 : w_regdst;
         alusrc        <= w_bubble ? 1'b0 : w_alusrc;
         aluop         <= w_bubble ? 2'b00 : w_aluop;
         npcout        <= if_id_npc;
         rdata1out     <= w_rdata1;
         rdata2out     <= w_rdata2;
         s_extendout   <= w_sext;
         instrout_2521 <= w_rs;
         instrout_2016 <= w_rt;
         instrout_1511 <= w_rd;
      end
   end

endmodule
